// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared helpers for the DDR read arbiter slice.
package ddr_rd_arbiter_pkg;

  // Advance a port index by one, wrapping at the port count.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ddr_rd_arbiter_rr_select.sv
// Round-robin selector: picks the lowest requesting index at or above ptr,
// wrapping past the top port back to 0. Purely combinational.
module rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     idx
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_PORTS);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// DDR read-burst arbiter: round-robin grants one requester at a time to the
// DDR controller, routes the return path to the owner, and flags bursts whose
// beat count disagrees with the granted length.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 10
`endif

module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = `DATA_WIDTH,
  parameter int ADDR_W    = `ADDR_SIZE,
  parameter int LEN_W     = `LEN_WIDTH
) (
  input  logic                      s_clk,
  input  logic                      s_rst,
  input  logic [NUM_PORTS-1:0]      s_rd_burst_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_rd_burst_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  s_rd_burst_len,
  output logic [DATA_W-1:0]         s_rd_burst_data,
  output logic [NUM_PORTS-1:0]      s_rd_burst_valid,
  output logic [NUM_PORTS-1:0]      s_rd_burst_finish,
  output logic                      m_rd_burst_req,
  output logic [ADDR_W-1:0]         m_rd_burst_addr,
  output logic [LEN_W-1:0]          m_rd_burst_len,
  input  logic [DATA_W-1:0]         m_rd_burst_data,
  input  logic                      m_rd_burst_valid,
  input  logic                      m_rd_burst_finish,
  output logic [NUM_PORTS-1:0]      o_grant,
  output logic                      o_len_err
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     sel_idx;
  logic [NUM_PORTS-1:0] sel_grant;
  logic [LEN_W:0]       beat_cnt;
  logic [LEN_W:0]       beat_total;

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_select (
    .req   (s_rd_burst_req),
    .ptr   (rr_ptr),
    .grant (sel_grant),
    .idx   (sel_idx)
  );

  // Return path: o_grant is zero outside BURST, so stray beats reach no port.
  assign s_rd_burst_data   = m_rd_burst_data;
  assign s_rd_burst_valid  = {NUM_PORTS{m_rd_burst_valid}} & o_grant;
  assign s_rd_burst_finish = {NUM_PORTS{m_rd_burst_finish}} & o_grant;

  // A beat landing with finish is counted before the length comparison.
  assign beat_total = beat_cnt + {{LEN_W{1'b0}}, m_rd_burst_valid};

  // Arbitration FSM: grant and latch request in IDLE, hold through BURST,
  // give requesters one RELEASE cycle to drop their registered req.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      gnt_idx         <= '0;
      beat_cnt        <= '0;
      o_grant         <= '0;
      o_len_err       <= 1'b0;
      m_rd_burst_req  <= 1'b0;
      m_rd_burst_addr <= '0;
      m_rd_burst_len  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_rd_burst_req) begin
            o_grant         <= sel_grant;
            gnt_idx         <= sel_idx;
            m_rd_burst_req  <= 1'b1;
            m_rd_burst_addr <= s_rd_burst_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            m_rd_burst_len  <= s_rd_burst_len[int'(sel_idx)*LEN_W +: LEN_W];
            beat_cnt        <= '0;
            state           <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (m_rd_burst_valid) begin
            beat_cnt <= beat_total;
          end
          if (m_rd_burst_finish) begin
            if (beat_total != {1'b0, m_rd_burst_len}) begin
              o_len_err <= 1'b1;
            end
            m_rd_burst_req <= 1'b0;
            o_grant        <= '0;
            rr_ptr         <= PTR_W'(wrap_inc(int'(gnt_idx), NUM_PORTS));
            state          <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter with a 4-port configuration and a simple
// DDR controller model driven from tasks.
module tb_ddr_rd_arbiter;

  localparam int NP     = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 10;

  logic                   s_clk;
  logic                   s_rst;
  logic [NP-1:0]          req;
  logic [NP*ADDR_W-1:0]   addr_bus;
  logic [NP*LEN_W-1:0]    len_bus;
  logic [DATA_W-1:0]      s_data;
  logic [NP-1:0]          s_valid;
  logic [NP-1:0]          s_finish;
  logic                   m_req;
  logic [ADDR_W-1:0]      m_addr;
  logic [LEN_W-1:0]       m_len;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_finish;
  logic [NP-1:0]          grant;
  logic                   len_err;

  int nvec = 0;
  int nerr = 0;

  // Valid-pulse bookkeeping for the port 0 / port 2 ordering scenario.
  int vcnt0  = 0;
  int v0_at2 = -1;
  bit seen2  = 1'b0;

  ddr_rd_arbiter #(
    .NUM_PORTS (NP),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W)
  ) dut (
    .s_clk             (s_clk),
    .s_rst             (s_rst),
    .s_rd_burst_req    (req),
    .s_rd_burst_addr   (addr_bus),
    .s_rd_burst_len    (len_bus),
    .s_rd_burst_data   (s_data),
    .s_rd_burst_valid  (s_valid),
    .s_rd_burst_finish (s_finish),
    .m_rd_burst_req    (m_req),
    .m_rd_burst_addr   (m_addr),
    .m_rd_burst_len    (m_len),
    .m_rd_burst_data   (m_data),
    .m_rd_burst_valid  (m_valid),
    .m_rd_burst_finish (m_finish),
    .o_grant           (grant),
    .o_len_err         (len_err)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  // Count port 0 valid pulses and snapshot the count at port 2's first pulse.
  always @(negedge s_clk) begin
    if (!s_rst && !seen2) begin
      if (s_valid[2]) begin
        seen2  = 1'b1;
        v0_at2 = vcnt0;
      end
      if (s_valid[0]) vcnt0 = vcnt0 + 1;
    end
  end

  function automatic logic [ADDR_W-1:0] port_addr(input int k);
    return ADDR_W'(32'h0000_0100 * (k + 1));
  endfunction

  // Serve one burst as the DDR controller: wait for the request, return
  // `beats` beats, then finish (optionally together with the last beat).
  task automatic serve(input logic [NP-1:0] exp_g, input logic [ADDR_W-1:0] exp_addr,
                       input int beats, input bit fin_with_last, input bit drop,
                       input int chg_port);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge s_clk);
      if (m_req) got = 1'b1;
    end
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL serve_wait: m_rd_burst_req never rose, expected grant %b", exp_g);
      return;
    end
    nvec++;
    if (grant !== exp_g) begin
      nerr++;
      $display("FAIL grant: got %b expected %b", grant, exp_g);
    end
    nvec++;
    if (m_len !== LEN_W'(4)) begin
      nerr++;
      $display("FAIL m_len: got %0d expected 4", m_len);
    end
    for (int i = 0; i < beats; i++) begin
      @(posedge s_clk); #1;
      m_valid  = 1'b1;
      m_data   = DATA_W'(32'hA5A0_0000 + i);
      m_finish = fin_with_last && (i == beats - 1);
      @(negedge s_clk);
      nvec++;
      if (s_valid !== exp_g || s_data !== m_data) begin
        nerr++;
        $display("FAIL beat%0d_route: valid %b data %h expected valid %b data %h",
                 i, s_valid, s_data, exp_g, m_data);
      end
      nvec++;
      if (m_addr !== exp_addr || grant !== exp_g || m_req !== 1'b1) begin
        nerr++;
        $display("FAIL beat%0d_hold: addr %h grant %b req %b expected addr %h grant %b req 1",
                 i, m_addr, grant, m_req, exp_addr, exp_g);
      end
      if (m_finish) begin
        nvec++;
        if (s_finish !== exp_g) begin
          nerr++;
          $display("FAIL finish_route: got %b expected %b", s_finish, exp_g);
        end
      end
      if (i == 0 && chg_port >= 0) begin
        addr_bus[chg_port*ADDR_W +: ADDR_W] = ADDR_W'(32'h2000);
        req[chg_port] = 1'b0;
      end
    end
    if (!fin_with_last) begin
      @(posedge s_clk); #1;
      m_valid  = 1'b0;
      m_finish = 1'b1;
      @(negedge s_clk);
      nvec++;
      if (s_finish !== exp_g || s_valid !== '0) begin
        nerr++;
        $display("FAIL finish_route: finish %b valid %b expected finish %b valid 0000",
                 s_finish, s_valid, exp_g);
      end
    end
    @(posedge s_clk); #1;
    m_valid  = 1'b0;
    m_finish = 1'b0;
    if (drop) req = req & ~exp_g;
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (2) @(posedge s_clk);
    #1;
    nvec++;
    if (m_req !== 1'b0 || m_addr !== '0 || m_len !== '0 || grant !== '0 || len_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: req %b addr %h len %0d grant %b err %b expected all 0",
               m_req, m_addr, m_len, grant, len_err);
    end
    s_rst = 1'b0;
    // Stray controller activity in IDLE must reach no port.
    @(posedge s_clk); #1;
    m_valid  = 1'b1;
    m_finish = 1'b1;
    @(negedge s_clk);
    nvec++;
    if (s_valid !== '0 || s_finish !== '0 || m_req !== 1'b0) begin
      nerr++;
      $display("FAIL stray_idle: valid %b finish %b req %b expected 0", s_valid, s_finish, m_req);
    end
    @(posedge s_clk); #1;
    m_valid  = 1'b0;
    m_finish = 1'b0;
  endtask

  task automatic test_two_ports();
    @(posedge s_clk); #1;
    req = 4'b0101;
    @(negedge s_clk);
    nvec++;
    if (m_req !== 1'b0) begin
      nerr++;
      $display("FAIL latency_early: m_req %b expected 0 before sampling edge", m_req);
    end
    @(negedge s_clk);
    nvec++;
    if (m_req !== 1'b1 || m_addr !== port_addr(0)) begin
      nerr++;
      $display("FAIL latency_grant: m_req %b addr %h expected 1 / %h", m_req, m_addr, port_addr(0));
    end
    serve(4'b0001, port_addr(0), 4, 1'b0, 1'b1, -1);
    serve(4'b0100, port_addr(2), 4, 1'b0, 1'b1, -1);
    nvec++;
    if (v0_at2 !== 4) begin
      nerr++;
      $display("FAIL order_0_then_2: port0 valid count %0d at first port2 beat expected 4", v0_at2);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] eg;
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    req = 4'b1111;
    for (int b = 0; b < 8; b++) begin
      eg = '0;
      eg[b % 4] = 1'b1;
      serve(eg, port_addr(b % 4), 4, 1'b0, 1'b0, -1);
      if (b == 7) begin
        req = '0;
      end else begin
        @(negedge s_clk);
        nvec++;
        if (m_req !== 1'b0 || grant !== '0) begin
          nerr++;
          $display("FAIL gap_release%0d: req %b grant %b expected 0", b, m_req, grant);
        end
        @(negedge s_clk);
        nvec++;
        if (m_req !== 1'b0) begin
          nerr++;
          $display("FAIL gap_idle%0d: req %b expected 0", b, m_req);
        end
        @(negedge s_clk);
        nvec++;
        if (m_req !== 1'b1) begin
          nerr++;
          $display("FAIL gap_regrant%0d: req %b expected 1", b, m_req);
        end
      end
    end
    repeat (3) @(posedge s_clk);
    #1;
  endtask

  task automatic test_addr_hold();
    addr_bus[1*ADDR_W +: ADDR_W] = ADDR_W'(32'h1000);
    req = 4'b0010;
    // Port 1 also drops its req after the first beat; the burst must still complete.
    serve(4'b0010, ADDR_W'(32'h1000), 4, 1'b1, 1'b1, 1);
    @(negedge s_clk);
    nvec++;
    if (len_err !== 1'b0) begin
      nerr++;
      $display("FAIL finish_with_beat: len_err %b expected 0", len_err);
    end
    addr_bus[1*ADDR_W +: ADDR_W] = port_addr(1);
  endtask

  task automatic test_len_err();
    req = 4'b0001;
    serve(4'b0001, port_addr(0), 3, 1'b0, 1'b1, -1);
    @(negedge s_clk);
    nvec++;
    if (len_err !== 1'b1) begin
      nerr++;
      $display("FAIL len_err_set: got %b expected 1", len_err);
    end
    req = 4'b0100;
    serve(4'b0100, port_addr(2), 4, 1'b0, 1'b1, -1);
    @(negedge s_clk);
    nvec++;
    if (len_err !== 1'b1) begin
      nerr++;
      $display("FAIL len_err_sticky: got %b expected 1", len_err);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    req = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 32 && !got; c++) begin
      @(negedge s_clk);
      if (m_req) got = 1'b1;
    end
    nvec++;
    if (!got || grant !== 4'b1000) begin
      nerr++;
      $display("FAIL mid_grant: req %b grant %b expected 1 / 1000", m_req, grant);
    end
    @(posedge s_clk); #1;
    m_valid = 1'b1;
    m_data  = DATA_W'(32'h0000_0B01);
    @(posedge s_clk); #1;
    m_data  = DATA_W'(32'h0000_0B02);
    #2;
    s_rst = 1'b1;
    #1;
    nvec++;
    if (m_req !== 1'b0 || m_addr !== '0 || m_len !== '0 || grant !== '0 || len_err !== 1'b0 ||
        s_valid !== '0 || s_finish !== '0) begin
      nerr++;
      $display("FAIL reset_mid: req %b addr %h len %0d grant %b err %b valid %b finish %b expected all 0",
               m_req, m_addr, m_len, grant, len_err, s_valid, s_finish);
    end
    m_valid = 1'b0;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    serve(4'b1000, port_addr(3), 4, 1'b0, 1'b1, -1);
  endtask

  initial begin
    s_rst    = 1'b1;
    req      = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_finish = 1'b0;
    for (int k = 0; k < NP; k++) begin
      addr_bus[k*ADDR_W +: ADDR_W] = port_addr(k);
      len_bus[k*LEN_W +: LEN_W]    = LEN_W'(4);
    end
    test_reset();
    test_two_ports();
    test_round_robin();
    test_addr_hold();
    test_len_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of DDR read requesters, range 2..8.
REQ-002 Parameters DATA_W, ADDR_W and LEN_W default to `DATA_WIDTH, `ADDR_SIZE and `LEN_WIDTH from the shared hyper-parameter header.
REQ-003 s_clk  in  1  clock, the DDR user clock.
REQ-004 s_rst  in  1  reset, asynchronous, active-high.
REQ-005 s_rd_burst_req  in  NUM_PORTS  per-port burst request, level, held until that port's finish.
REQ-006 s_rd_burst_addr  in  NUM_PORTS*ADDR_W  packed per-port byte address; port k occupies slice k.
REQ-007 s_rd_burst_len  in  NUM_PORTS*LEN_W  packed per-port burst length in beats.
REQ-008 s_rd_burst_data  out  DATA_W  DDR read data, broadcast to all ports.
REQ-009 s_rd_burst_valid  out  NUM_PORTS  per-port data valid.
REQ-010 s_rd_burst_finish  out  NUM_PORTS  per-port burst-finish pulse.
REQ-011 m_rd_burst_req / m_rd_burst_addr / m_rd_burst_len  out  1/ADDR_W/LEN_W  request to the DDR controller.
REQ-012 m_rd_burst_data / m_rd_burst_valid / m_rd_burst_finish  in  DATA_W/1/1  DDR controller return path.
REQ-013 o_grant  out  NUM_PORTS  one-hot current owner; all zeros when idle.
REQ-014 o_len_err  out  1  sticky: beat count at finish differed from the granted length.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BURST and RELEASE.
REQ-016 IDLE: if any s_rd_burst_req bit is set, select one port by round-robin starting at rr_ptr, then go to BURST.
- All of o_grant, m_rd_burst_addr, m_rd_burst_len and m_rd_burst_req=1 SHALL be registered on that same edge.
- Latency: request sampled at edge t, m_rd_burst_req high after edge t.
REQ-017 BURST: m_rd_burst_req, the latched addr/len and o_grant SHALL stay constant until m_rd_burst_finish.
REQ-018 In BURST, an m_rd_burst_finish pulse SHALL clear m_rd_burst_req and o_grant on the next edge, set rr_ptr to granted index+1 modulo NUM_PORTS, and enter RELEASE.
REQ-019 RELEASE SHALL last exactly one cycle, sample no requests, then return to IDLE. This gives requesters one cycle to deassert their registered req.
REQ-020 s_rd_burst_valid[k] SHALL equal m_rd_burst_valid AND o_grant[k], combinationally with no added latency.
REQ-021 s_rd_burst_finish[k] SHALL equal m_rd_burst_finish AND o_grant[k], combinationally.
REQ-022 s_rd_burst_data SHALL equal m_rd_burst_data unconditionally.
REQ-023 Beat counter:
- Width LEN_W+1.
- Cleared on grant; incremented on each m_rd_burst_valid in BURST.
- At finish, the count is compared with the latched length; on mismatch o_len_err SHALL be set and held until reset.
REQ-024 m_rd_burst_valid or m_rd_burst_finish arriving outside BURST SHALL be ignored: no port output and no count.
REQ-025 A requester dropping its req after grant SHALL NOT abort the burst; the burst completes and that port still receives valid/finish.
REQ-026 Requests arriving in BURST or RELEASE SHALL be held pending and arbitrated in the next IDLE cycle; no request is lost while held.
REQ-027 Simultaneous requests SHALL be resolved by the lowest index at or above rr_ptr, wrapping. No port waits more than NUM_PORTS-1 bursts.
REQ-028 An m_rd_burst_valid and m_rd_burst_finish in the same cycle SHALL count that beat before the length comparison.

Reset
REQ-029 On s_rst the block SHALL asynchronously enter IDLE with all outputs zeroed: m_rd_burst_req=0, m_rd_burst_addr=0, m_rd_burst_len=0, o_grant=0, o_len_err=0. rr_ptr and the beat counter SHALL also be zeroed.
REQ-030 Reset mid-burst SHALL abandon the burst without emitting finish to any port; the DDR controller shares s_rst and is reset with it.

Structure
REQ-031 DATA_W, ADDR_W and LEN_W come from the shared hyper-parameter header; state encodings stay local to the module.
REQ-032 The round-robin selector SHALL be a separate combinational sub-module rr_select (inputs req vector and ptr; outputs one-hot grant and index). All sequencing stays in ddr_rd_arbiter.

Verification
REQ-033 Setup: NUM_PORTS=4, all lengths 4, DDR model returns 4 beats then finish.
- Stimulus: ports 0 and 2 request together from reset.
- Required: port 0 is served first, then port 2.
- Required: s_rd_burst_valid[0] pulses exactly 4 times before any s_rd_burst_valid[2] pulse.
REQ-034 Stimulus: all 4 ports request continuously for 8 bursts.
- Required grant order: 0,1,2,3,0,1,2,3.
- Required gap: exactly one RELEASE cycle plus one IDLE cycle between each finish and the next m_rd_burst_req.
REQ-035 Stimulus: port 1 requests addr 0x1000 and len 4, then changes its addr bus to 0x2000 mid-burst.
- Required: m_rd_burst_addr stays 0x1000 until finish.
REQ-036 Stimulus: the model returns 3 beats, then finish, for len 4.
- Required: o_len_err=1 and stays 1.
- Required: the next burst is still granted normally.
REQ-037 Stimulus: assert s_rst during the second beat of port 3's burst.
- Required: all outputs are 0 immediately.
- Required: after release, a pending port 3 request is granted first, since rr_ptr is 0 and ports 0..2 are idle.
